// File: rtl/qtext_pkg.sv
// Shared constants, state encoding and helpers for the spoken-text word sequencer.
// Counter widths are derived from the word and FIFO sizes.
package qtext_pkg;

    localparam int unsigned MAX_CHARS  = 10;
    localparam int unsigned FIFO_DEPTH = 8;
    localparam logic [7:0]  SPACE_CHAR = 8'h20;

    localparam int unsigned CHAR_CNT_W = $clog2(MAX_CHARS + 1);
    localparam int unsigned FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [CHAR_CNT_W-1:0] LAST_CHAR = CHAR_CNT_W'(MAX_CHARS - 1);
    localparam logic [FIFO_CNT_W-1:0] FIFO_FULL = FIFO_CNT_W'(FIFO_DEPTH);

    typedef logic [1:0] state_t;

    localparam state_t StIdle     = 2'd0;
    localparam state_t StLoad     = 2'd1;
    localparam state_t StPush     = 2'd2;
    localparam state_t StFullWait = 2'd3;

    // A space only terminates a word that already holds characters.
    function automatic logic is_word_end(input logic [7:0]            b,
                                         input logic [CHAR_CNT_W-1:0] cnt);
        return ((b == SPACE_CHAR) && (cnt != '0)) || (cnt == LAST_CHAR);
    endfunction

    function automatic logic is_lone_space(input logic [7:0]            b,
                                           input logic [CHAR_CNT_W-1:0] cnt);
        return (b == SPACE_CHAR) && (cnt == '0);
    endfunction

endpackage

// File: rtl/qtext_seq_ctrl_if.sv
// Byte-stream, datapath-control and encoder handshake signals of the word sequencer.
// The controller takes the slave side; the front end / datapath model takes master.
interface qtext_seq_ctrl_if;

    logic       in_valid;
    logic [7:0] in_byte;
    logic       in_ready;
    logic       flush;
    logic       enc_ready;
    logic [7:0] data_out;
    logic       qen;
    logic       fen;
    logic       wr;
    logic       ken;
    logic       out_valid;

    modport master (
        output in_valid,
        output in_byte,
        output flush,
        output enc_ready,
        input  in_ready,
        input  data_out,
        input  qen,
        input  fen,
        input  wr,
        input  ken,
        input  out_valid
    );

    modport slave (
        input  in_valid,
        input  in_byte,
        input  flush,
        input  enc_ready,
        output in_ready,
        output data_out,
        output qen,
        output fen,
        output wr,
        output ken,
        output out_valid
    );

endinterface

// File: rtl/qtext_fifo_arb.sv
// Single-port word FIFO arbiter: push/pop grant, occupancy count and the pop->ken stage.
// Push always wins the port; a pop waits until the previous pop's ken has fired.
module qtext_fifo_arb
    import qtext_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_req_i,
    input  logic                  enc_ready_i,
    output logic                  push_gnt_o,
    output logic                  fen_o,
    output logic                  wr_o,
    output logic                  ken_o,
    output logic [FIFO_CNT_W-1:0] fifo_cnt_o
);

    logic [FIFO_CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
    logic                  ken_q;
    logic                  full;
    logic                  pop_gnt;

    always_comb begin
        full       = (fifo_cnt_q == FIFO_FULL);
        push_gnt_o = push_req_i && !full;
        pop_gnt    = (fifo_cnt_q != '0) && enc_ready_i && !ken_q && !push_gnt_o;

        fen_o = push_gnt_o || pop_gnt;
        wr_o  = push_gnt_o;

        fifo_cnt_d = fifo_cnt_q;
        if (push_gnt_o) begin
            fifo_cnt_d = fifo_cnt_q + FIFO_CNT_W'(1);
        end else if (pop_gnt) begin
            fifo_cnt_d = fifo_cnt_q - FIFO_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_cnt_q <= '0;
            ken_q      <= 1'b0;
        end else begin
            fifo_cnt_q <= fifo_cnt_d;
            ken_q      <= pop_gnt;
        end
    end

    assign ken_o      = ken_q;
    assign fifo_cnt_o = fifo_cnt_q;

endmodule

// File: rtl/qtext_seq_ctrl.sv
// Word-path sequencer: accepts ASCII bytes, re-times them onto the shift register (qen),
// detects word ends and schedules FIFO pushes; pops run independently in qtext_fifo_arb.
module qtext_seq_ctrl
    import qtext_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    qtext_seq_ctrl_if.slave       bus,
    output logic [CHAR_CNT_W-1:0] char_cnt,
    output logic [FIFO_CNT_W-1:0] fifo_cnt,
    output logic                  overflow
);

    state_t                state_q, state_d;
    logic [CHAR_CNT_W-1:0] char_cnt_q, char_cnt_d;
    logic [7:0]            data_q;
    logic                  qen_q;
    logic                  overflow_q, overflow_d;

    logic in_ready;
    logic accept;
    logic flush_go;
    logic go_idle;
    logic push_req;
    logic push_gnt;
    logic ken;

    always_comb begin
        flush_go = bus.flush && (char_cnt_q != '0);
        go_idle  = !en && (char_cnt_q == '0);
        in_ready = (state_q == StLoad) && !flush_go && !go_idle;
        accept   = bus.in_valid && in_ready;
        // Hold the push off while the last byte is still being shifted in.
        push_req = (state_q == StPush) && !qen_q;
    end

    always_comb begin
        state_d    = state_q;
        char_cnt_d = char_cnt_q;
        overflow_d = overflow_q;

        unique case (state_q)
            StIdle: begin
                if (en) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                if (flush_go) begin
                    state_d = StPush;
                end else if (go_idle) begin
                    state_d = StIdle;
                end else if (accept) begin
                    if (!is_lone_space(bus.in_byte, char_cnt_q)) begin
                        char_cnt_d = char_cnt_q + CHAR_CNT_W'(1);
                    end
                    if (is_word_end(bus.in_byte, char_cnt_q)) begin
                        state_d = StPush;
                    end
                end
            end
            StPush: begin
                if (push_req) begin
                    if (push_gnt) begin
                        char_cnt_d = '0;
                        state_d    = StLoad;
                    end else begin
                        state_d = StFullWait;
                    end
                end
            end
            StFullWait: begin
                if (bus.flush) begin
                    overflow_d = 1'b1;
                end
                // ken marks the pop that freed a slot.
                if (ken) begin
                    state_d = StPush;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            char_cnt_q <= '0;
            data_q     <= 8'h00;
            qen_q      <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            char_cnt_q <= char_cnt_d;
            qen_q      <= accept;
            overflow_q <= overflow_d;
            if (accept) begin
                data_q <= bus.in_byte;
            end
        end
    end

    qtext_fifo_arb u_arb (
        .clk         (clk),
        .rst         (rst),
        .push_req_i  (push_req),
        .enc_ready_i (bus.enc_ready),
        .push_gnt_o  (push_gnt),
        .fen_o       (bus.fen),
        .wr_o        (bus.wr),
        .ken_o       (ken),
        .fifo_cnt_o  (fifo_cnt)
    );

    assign bus.in_ready  = in_ready;
    assign bus.data_out  = data_q;
    assign bus.qen       = qen_q;
    assign bus.ken       = ken;
    assign bus.out_valid = ken;
    assign char_cnt      = char_cnt_q;
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_qtext_seq_ctrl.sv
// Directed bench for qtext_seq_ctrl: word loading, max-length words, full FIFO,
// push/pop collision, leading spaces with flush, and mid-word reset.
module tb_qtext_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] char_cnt;
    logic [3:0] fifo_cnt;
    logic       overflow;

    int ntot = 0;
    int nbad = 0;
    int kens;

    qtext_seq_ctrl_if bus ();

    qtext_seq_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .bus      (bus),
        .char_cnt (char_cnt),
        .fifo_cnt (fifo_cnt),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        if (obs !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [7:0] b);
        bus.in_valid = v;
        bus.in_byte  = b;
    endtask

    // "A " from a LOAD cycle; returns having ticked into the push cycle.
    task automatic send_word();
        tick(); drive(1'b1, 8'h41);
        tick(); drive(1'b1, 8'h20);
        tick(); drive(1'b0, 8'h00);
        tick();
    endtask

    initial begin
        rst = 1'b1; en = 1'b0;
        bus.in_valid = 1'b0; bus.in_byte = 8'h00; bus.flush = 1'b0; bus.enc_ready = 1'b0;
        tick(); tick();
        mid();
        check("rst_qen", bus.qen, 0);
        check("rst_data", bus.data_out, 0);
        check("rst_rdy", bus.in_ready, 0);
        check("rst_fen", bus.fen, 0);
        check("rst_ken", bus.ken, 0);
        check("rst_cnts", {char_cnt, fifo_cnt}, 0);

        // "HI "
        tick(); rst = 1'b0; en = 1'b1;
        mid(); check("idle_rdy", bus.in_ready, 0);
        tick(); drive(1'b1, 8'h48);
        mid(); check("load_rdy", bus.in_ready, 1);
        tick(); drive(1'b1, 8'h49);
        mid(); check("hi_qen1", bus.qen, 1); check("hi_d1", bus.data_out, 8'h48);
        check("hi_cc1", char_cnt, 1);
        tick(); drive(1'b1, 8'h20);
        mid(); check("hi_qen2", bus.qen, 1); check("hi_d2", bus.data_out, 8'h49);
        check("hi_cc2", char_cnt, 2);
        tick(); drive(1'b0, 8'h00);
        mid(); check("hi_qen3", bus.qen, 1); check("hi_d3", bus.data_out, 8'h20);
        check("hi_rdy_lo", bus.in_ready, 0); check("hi_nofen", bus.fen, 0);
        tick();
        mid(); check("hi_push", {bus.fen, bus.wr}, 2'b11); check("hi_rdy_lo2", bus.in_ready, 0);

        // Ten 'A' bytes, no space
        tick(); drive(1'b1, 8'h41);
        mid(); check("hi_fifo", fifo_cnt, 1); check("hi_cc0", char_cnt, 0);
        check("hi_fen0", bus.fen, 0); check("hi_qen0", bus.qen, 0);
        check("a_rdy0", bus.in_ready, 1);
        for (int i = 1; i < 10; i++) begin
            tick();
            mid(); check("a_rdy", bus.in_ready, 1);
        end
        check("a_cc9", char_cnt, 9);
        tick(); drive(1'b0, 8'h00);
        mid(); check("a_qen", bus.qen, 1); check("a_cc10", char_cnt, 10);
        check("a_rdy_lo1", bus.in_ready, 0);
        tick();
        mid(); check("a_push", {bus.fen, bus.wr}, 2'b11); check("a_rdy_lo2", bus.in_ready, 0);
        check("a_cc10b", char_cnt, 10);

        // Push and pop contend in the same cycle
        tick(); drive(1'b1, 8'h42);
        mid(); check("a_rdy_hi", bus.in_ready, 1); check("a_cc0", char_cnt, 0);
        check("a_fifo", fifo_cnt, 2);
        tick(); drive(1'b1, 8'h20);
        tick(); drive(1'b0, 8'h00);
        mid(); check("pp_rdy", bus.in_ready, 0);
        tick(); bus.enc_ready = 1'b1;
        mid(); check("pp_push", {bus.fen, bus.wr}, 2'b11); check("pp_ken0", bus.ken, 0);
        tick();
        mid(); check("pp_fifo3", fifo_cnt, 3); check("pp_pop", {bus.fen, bus.wr}, 2'b10);
        check("pp_ken_early", bus.ken, 0);
        tick(); bus.enc_ready = 1'b0;
        mid(); check("pp_ken", {bus.ken, bus.out_valid}, 2'b11); check("pp_fifo2", fifo_cnt, 2);
        check("pp_fen0", bus.fen, 0);
        tick();
        mid(); check("pp_ken_off", bus.ken, 0); check("pp_fifo2b", fifo_cnt, 2);

        // Fill to 8 words, then a 9th into a full FIFO
        repeat (6) send_word();
        tick(); drive(1'b1, 8'h41);
        mid(); check("full_fifo8", fifo_cnt, 8);
        tick(); drive(1'b1, 8'h20);
        tick(); drive(1'b0, 8'h00);
        mid(); check("full_rdy1", bus.in_ready, 0);
        tick();
        mid(); check("full_nofen", bus.fen, 0); check("full_rdy2", bus.in_ready, 0);
        tick(); bus.flush = 1'b1;
        mid(); check("fw_nofen", bus.fen, 0); check("fw_rdy", bus.in_ready, 0);
        check("fw_ovf0", overflow, 0);
        tick(); bus.flush = 1'b0; bus.enc_ready = 1'b1;
        mid(); check("fw_ovf1", overflow, 1); check("fw_pop", {bus.fen, bus.wr}, 2'b10);
        tick(); bus.enc_ready = 1'b0;
        mid(); check("fw_ken", {bus.ken, bus.out_valid}, 2'b11); check("fw_fifo7", fifo_cnt, 7);
        check("fw_fen0", bus.fen, 0);
        tick();
        mid(); check("fw_push", {bus.fen, bus.wr}, 2'b11); check("fw_ken0", bus.ken, 0);
        tick();
        mid(); check("fw_fifo8", fifo_cnt, 8); check("fw_cc0", char_cnt, 0);
        check("fw_rdy_hi", bus.in_ready, 1);

        // Drain six words: one pop every other cycle
        bus.enc_ready = 1'b1;
        kens = 0;
        for (int i = 0; i < 11; i++) begin
            tick();
            mid(); kens += int'(bus.ken);
        end
        check("drain_kens", kens, 6);
        check("drain_fifo2", fifo_cnt, 2);
        bus.enc_ready = 1'b0;

        // Mid-word reset with char_cnt=3, fifo_cnt=2
        drive(1'b1, 8'h41);
        tick(); drive(1'b1, 8'h42);
        tick(); drive(1'b1, 8'h43);
        tick(); drive(1'b0, 8'h00);
        mid(); check("mw_cc3", char_cnt, 3); check("mw_fifo2", fifo_cnt, 2);
        check("mw_d", bus.data_out, 8'h43); check("mw_ovf", overflow, 1);
        rst = 1'b1;
        tick(); rst = 1'b0;
        mid();
        check("mr_outs", {bus.qen, bus.fen, bus.wr, bus.ken, bus.out_valid, bus.in_ready}, 0);
        check("mr_data", bus.data_out, 0);
        check("mr_cnts", {char_cnt, fifo_cnt}, 0);
        check("mr_ovf", overflow, 0);

        // Leading spaces then flush, then "A" + flush
        tick(); drive(1'b1, 8'h20);
        tick(); drive(1'b1, 8'h20);
        mid(); check("sp_qen1", bus.qen, 1); check("sp_d", bus.data_out, 8'h20);
        check("sp_cc0", char_cnt, 0);
        tick(); drive(1'b0, 8'h00); bus.flush = 1'b1;
        mid(); check("sp_qen2", bus.qen, 1); check("sp_rdy", bus.in_ready, 1);
        tick(); bus.flush = 1'b0;
        mid(); check("sp_nofen", {bus.qen, bus.fen}, 0); check("sp_rdy2", bus.in_ready, 1);
        tick(); drive(1'b1, 8'h41);
        mid(); check("sp_fifo0", fifo_cnt, 0); check("sp_nofen2", bus.fen, 0);
        tick(); drive(1'b0, 8'h00); bus.flush = 1'b1;
        mid(); check("fl_cc1", char_cnt, 1); check("fl_rdy", bus.in_ready, 0);
        check("fl_qen", bus.qen, 1);
        tick(); bus.flush = 1'b0;
        mid(); check("fl_push", {bus.fen, bus.wr}, 2'b11);
        tick(); en = 1'b0;
        mid(); check("fl_fifo1", fifo_cnt, 1); check("fl_cc0", char_cnt, 0);
        check("en_off_rdy", bus.in_ready, 0);
        tick();
        mid(); check("idle_again", bus.in_ready, 0);

        $display("test done: total=%0d bad=%0d", ntot, nbad);
        $finish;
    end

endmodule
